// File: rtl/chacha_rounds.sv
// chacha_rounds: iterative ChaCha permutation core.
//
// Takes a 16-word state over in_valid_i/in_ready_o and applies ROUNDS rounds.
// Column and diagonal rounds alternate, and QR_PAR quarter-round units run per
// cycle. The permuted state comes back over out_valid_o/out_ready_i.
//
// Parameters:
//   ROUNDS  even, 2..20 (8/12/20 for ChaCha8/12/20)
//   QR_PAR  quarter-rounds per cycle: 1, 2 or 4
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   input state valid
//   in_ready_o   core idle, can accept a state
//   state_i      512-bit input state, word i at [32*i +: 32]
//   out_valid_o  result valid (held until out_ready_i)
//   out_ready_i  consumer accepts result
//   state_o      512-bit working register / result, same packing
//   busy_o       high while rounds are being computed
//
// Optional feature: define CHACHA_FEEDFORWARD_EN to add the saved input state
// to the permutation on the final step (RFC 8439 block function output).
module chacha_rounds #(
  parameter int unsigned ROUNDS = 20,
  parameter int unsigned QR_PAR = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [511:0] state_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [511:0] state_o,
  output logic         busy_o
);

  localparam int unsigned NSTEPS = (ROUNDS / 2) * (8 / QR_PAR);
  localparam int unsigned CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam int unsigned QSH    = $clog2(QR_PAR);

  if ((ROUNDS % 2) != 0 || ROUNDS < 2 || ROUNDS > 20) begin : g_bad_rounds
    $error("chacha_rounds: ROUNDS must be even and in 2..20");
  end
  if (QR_PAR != 1 && QR_PAR != 2 && QR_PAR != 4) begin : g_bad_qr_par
    $error("chacha_rounds: QR_PAR must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

  fsm_e          state_q;
  logic [CW-1:0] cnt_q;
  logic [511:0]  work_q;
  logic [511:0]  step_state;
  logic          last_step;
  logic          accept;

  assign accept    = (state_q == StIdle) && in_valid_i;
  assign last_step = (cnt_q == CW'(NSTEPS - 1));

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] quarter(input logic [31:0] a_in, input logic [31:0] b_in,
                                           input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    a = a_in;
    b = b_in;
    c = c_in;
    d = d_in;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

`ifdef CHACHA_FEEDFORWARD_EN
  logic [511:0] saved_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      saved_q <= '0;
    end else if (accept) begin
      saved_q <= state_i;
    end
  end
`endif

  // One step: quarter-round list entries base .. base+QR_PAR-1. Entries 0-3 are
  // columns, 4-7 diagonals; a diagonal shifts row r by r lanes.
  logic [31:0]  w [16];
  logic [2:0]   base;
  logic [2:0]   ent;
  logic [1:0]   lane;
  logic         diag;
  logic [3:0]   ia, ib, ic, id;
  logic [127:0] qr_out;

  always_comb begin
    base   = 3'({3'b000, cnt_q} << QSH);
    ent    = '0;
    lane   = '0;
    diag   = 1'b0;
    ia     = '0;
    ib     = '0;
    ic     = '0;
    id     = '0;
    qr_out = '0;
    for (int k = 0; k < 16; k++) begin
      w[k] = work_q[32*k +: 32];
    end
    for (int j = 0; j < QR_PAR; j++) begin
      ent    = base + 3'(j);
      lane   = ent[1:0];
      diag   = ent[2];
      ia     = {2'b00, lane};
      ib     = {2'b01, lane + {1'b0, diag}};
      ic     = {2'b10, lane + {diag, 1'b0}};
      id     = {2'b11, lane + {diag, diag}};
      qr_out = quarter(w[ia], w[ib], w[ic], w[id]);
      w[ia]  = qr_out[127:96];
      w[ib]  = qr_out[95:64];
      w[ic]  = qr_out[63:32];
      w[id]  = qr_out[31:0];
    end
    for (int k = 0; k < 16; k++) begin
`ifdef CHACHA_FEEDFORWARD_EN
      step_state[32*k +: 32] = w[k] + (last_step ? saved_q[32*k +: 32] : 32'h0);
`else
      step_state[32*k +: 32] = w[k];
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            work_q  <= state_i;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          work_q <= step_state;
          if (last_step) begin
            cnt_q   <= '0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q == StRun);
  assign state_o     = work_q;

endmodule

// File: tb/tb_chacha_rounds.sv
// Directed bench for chacha_rounds: RFC 8439 block vector, zero state,
// backpressure, asynchronous reset mid-run, and latency/result checks for
// QR_PAR=1/2 and ROUNDS=8/12 variants.
module tb_chacha_rounds;

`ifdef CHACHA_FEEDFORWARD_EN
  localparam bit          FF     = 1'b1;
  localparam logic [31:0] RFC_W0 = 32'he4e7f110;
  localparam logic [31:0] RFC_W1 = 32'h15593bd1;
  localparam logic [31:0] RFC_W2 = 32'h1fdd0f50;
  localparam logic [31:0] RFC_W3 = 32'hc47120a3;
`else
  localparam bit          FF     = 1'b0;
  localparam logic [31:0] RFC_W0 = 32'h837778ab;
  localparam logic [31:0] RFC_W1 = 32'he238d763;
  localparam logic [31:0] RFC_W2 = 32'ha67ae21e;
  localparam logic [31:0] RFC_W3 = 32'h5950bb2f;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] state_out;
  logic         busy;

  logic         v_in_valid;
  logic [3:0]   v_in_ready, v_out_valid, v_busy;
  logic [511:0] v_state_out [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chacha_rounds #(.ROUNDS(20), .QR_PAR(4)) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .state_i    (state_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .state_o    (state_out),
    .busy_o     (busy)
  );

  // Variants: 0 -> (20,1), 1 -> (20,2), 2 -> (8,4), 3 -> (12,4)
  for (genvar g = 0; g < 4; g++) begin : g_var
    localparam int unsigned VR = (g < 2) ? 20 : ((g == 2) ? 8 : 12);
    localparam int unsigned VQ = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    chacha_rounds #(.ROUNDS(VR), .QR_PAR(VQ)) u_var (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_valid_i (v_in_valid),
      .in_ready_o (v_in_ready[g]),
      .state_i    (state_in),
      .out_valid_o(v_out_valid[g]),
      .out_ready_i(1'b0),
      .state_o    (v_state_out[g]),
      .busy_o     (v_busy[g])
    );
  end

  // Straightforward reference permutation over the explicit quarter-round table.
  function automatic logic [511:0] model(input logic [511:0] s, input int rounds, input bit ff);
    int unsigned t [8][4];
    logic [31:0] x [16];
    logic [31:0] a, b, c, d;
    logic [511:0] r;
    t = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
          '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    for (int k = 0; k < 16; k++) x[k] = s[32*k +: 32];
    for (int dr = 0; dr < rounds / 2; dr++) begin
      for (int e = 0; e < 8; e++) begin
        a = x[t[e][0]]; b = x[t[e][1]]; c = x[t[e][2]]; d = x[t[e][3]];
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        x[t[e][0]] = a; x[t[e][1]] = b; x[t[e][2]] = c; x[t[e][3]] = d;
      end
    end
    for (int k = 0; k < 16; k++) r[32*k +: 32] = x[k] + (ff ? s[32*k +: 32] : 32'h0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call at the negedge following the accept edge; returns edges until out_valid.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic send_main(input logic [511:0] s);
    @(negedge clk);
    in_valid = 1'b1;
    state_in = s;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [511:0] rfc_in;
  logic [511:0] rfc_exp;
  int           lat;
  int           vlat [4];

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    v_in_valid = 1'b0;
    state_in   = '0;

    rfc_in = '0;
    rfc_in[32*0 +: 32] = 32'h61707865;
    rfc_in[32*1 +: 32] = 32'h3320646e;
    rfc_in[32*2 +: 32] = 32'h79622d32;
    rfc_in[32*3 +: 32] = 32'h6b206574;
    for (int i = 0; i < 8; i++)
      rfc_in[32*(4+i) +: 32] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    rfc_in[32*12 +: 32] = 32'h00000001;
    rfc_in[32*13 +: 32] = 32'h09000000;
    rfc_in[32*14 +: 32] = 32'h4a000000;
    rfc_in[32*15 +: 32] = 32'h00000000;
    rfc_exp = model(rfc_in, 20, FF);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 512'(in_ready), 512'(1));
    chk("reset_out_valid", 512'(out_valid), 512'(0));
    chk("reset_busy", 512'(busy), 512'(0));
    chk("reset_state_o", state_out, '0);

    // RFC 8439 block vector
    send_main(rfc_in);
    wait_done(lat);
    chk("rfc_latency", 512'(lat), 512'(20));
    chk("rfc_word0", 512'(state_out[31:0]), 512'(RFC_W0));
    chk("rfc_word1", 512'(state_out[63:32]), 512'(RFC_W1));
    chk("rfc_word2", 512'(state_out[95:64]), 512'(RFC_W2));
    chk("rfc_word3", 512'(state_out[127:96]), 512'(RFC_W3));
    chk("rfc_full", state_out, rfc_exp);
    chk("done_in_ready", 512'(in_ready), 512'(0));

    // Backpressure with a competing input that must not be captured
    in_valid = 1'b1;
    state_in = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_state_stable", state_out, rfc_exp);
      chk("bp_out_valid", 512'(out_valid), 512'(1));
      chk("bp_in_ready", 512'(in_ready), 512'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_idle", 512'(in_ready), 512'(1));
    chk("release_state_kept", state_out, rfc_exp);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_busy", 512'(busy), 512'(1));
    wait_done(lat);
    chk("zero_latency", 512'(lat), 512'(20));
    chk("zero_state", state_out, '0);
    handshake();

    // Asynchronous reset at step 7
    send_main(rfc_in);
    repeat (7) @(negedge clk);
    chk("pre_reset_busy", 512'(busy), 512'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 512'(in_ready), 512'(1));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_state_o", state_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    send_main(rfc_in);
    wait_done(lat);
    chk("post_rst_latency", 512'(lat), 512'(20));
    chk("post_rst_full", state_out, rfc_exp);
    handshake();

    // Variants, all started together on the same edge
    @(negedge clk);
    v_in_valid = 1'b1;
    state_in   = rfc_in;
    @(negedge clk);
    v_in_valid = 1'b0;
    for (int g = 0; g < 4; g++) vlat[g] = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++)
        if (v_out_valid[g] && vlat[g] < 0) vlat[g] = n;
    end
    chk("q1_latency", 512'(vlat[0]), 512'(80));
    chk("q2_latency", 512'(vlat[1]), 512'(40));
    chk("r8_latency", 512'(vlat[2]), 512'(8));
    chk("r12_latency", 512'(vlat[3]), 512'(12));
    chk("q1_word0", 512'(v_state_out[0][31:0]), 512'(RFC_W0));
    chk("q1_full", v_state_out[0], rfc_exp);
    chk("q2_full", v_state_out[1], rfc_exp);
    chk("r8_full", v_state_out[2], model(rfc_in, 8, FF));
    chk("r12_full", v_state_out[3], model(rfc_in, 12, FF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
